// File: rtl/ps2_scan_rx_if.sv
// Pin-side and scan-code-side signals of the PS/2 keyboard receiver.
// The master drives the raw PS/2 pins and consumes scan codes; the slave
// is the receiver itself.
interface ps2_scan_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scan_code,
    input  scan_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scan_code,
    output scan_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw pins,
// deserialises 11-bit device-to-host frames (start, d0..d7, odd parity,
// stop) and emits each good scan code with a one-cycle strobe. Malformed
// or stalled frames are dropped and flagged with a one-cycle frame_err.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_scan_rx_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Synchroniser flops; idle PS/2 lines are high, so they reset to 1.
  logic clk_meta_q, clk_sync_q;
  logic data_meta_q, data_sync_q;

  // Glitch filter on the synchronised clock.
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_evt;

  // Frame state.
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout;

  // Registered outputs.
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  // Two-flop synchronisers for both asynchronous PS/2 pins.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= bus.ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= bus.ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Filter: the level flips only after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the run.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // The filtered clock's 1->0 transition marks a bit-sampling point.
  assign fall_evt = filt_q & ~filt_d;

  // Filter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame FSM next state, watchdog and output strobes. Timeout takes
  // priority over a coincident falling edge, which is then not consumed.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    if (state_q == IDLE || fall_evt) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (timeout) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      par_d       = 1'b0;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else if (fall_evt) begin
      unique case (state_q)
        IDLE: begin
          // A high start bit is line noise, not a frame: ignore it quietly.
          if (!data_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_sync_q;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = data_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_sync_q && (^{shift_q, par_q})) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Frame state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.scan_code  = scan_code_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx. A frame-level model predicts, per
// transmitted frame, either a good scan code or an error; one compare
// process matches every strobe against that queue and checks scan_code
// every cycle. The PS/2 clock is scaled down so the run stays short.
module tb_ps2_scan_rx;

  localparam int FILTER_LEN = 8;
  localparam int TO         = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  ps2_scan_rx_if bus_if ();

  ps2_scan_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_code = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         half = 20;
  int         last_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Odd parity bit from the frame rule: data plus parity has an odd number of ones.
  function automatic logic odd_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data settles during the high phase, the device then
  // drives the clock low for a half period. An optional short low glitch
  // (FILTER_LEN-2 cycles) is placed inside the high phase.
  task automatic send_bit(input logic b, input bit glitch);
    bus_if.ps2_data = b;
    if (glitch) begin
      tick(4);
      bus_if.ps2_clk = 1'b0;
      tick(FILTER_LEN - 2);
      bus_if.ps2_clk = 1'b1;
      tick(half - 4 - (FILTER_LEN - 2));
    end else begin
      tick(half);
    end
    bus_if.ps2_clk = 1'b0;
    last_fall_cyc  = cyc;
    tick(half);
    bus_if.ps2_clk = 1'b1;
  endtask

  // Full frame; the expected outcome is queued before transmission.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop_v,
                            input bit glitch);
    logic [10:0] bits;
    exp_t        e;
    bits     = {stop_v, odd_par(b) ^ bad_par, b, 1'b0};
    e.is_err = bad_par || !stop_v;
    e.code   = b;
    exp_q.push_back(e);
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
    bus_if.ps2_data = 1'b1;
  endtask

  // Compare process: strobes against the model queue, scan_code every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_code = 8'h00;
      check("reset_outputs",
            {21'd0, bus_if.scan_code, bus_if.scan_valid, bus_if.frame_err, bus_if.busy}, 32'd0);
    end else begin
      if (bus_if.scan_valid && bus_if.frame_err) begin
        check("strobe_overlap", 32'd1, 32'd0);
      end else if (bus_if.scan_valid || bus_if.frame_err) begin
        if (bus_if.scan_valid) n_valid++;
        else n_err++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, bus_if.scan_valid, bus_if.frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_is_err", {31'd0, bus_if.frame_err}, {31'd0, e.is_err});
          if (!e.is_err) model_code = e.code;
        end
      end
      check("scan_code", {24'd0, bus_if.scan_code}, {24'd0, model_code});
    end
  end

  initial begin
    int v0, e0, d;
    bit seen;

    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    rst_n = 1'b0;
    tick(5);
    check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    check("reset_code", {24'd0, bus_if.scan_code}, 32'h00);
    rst_n = 1'b1;
    tick(30);

    // Pin the model's parity rule with hand-computed values.
    check("model_par_1C", {31'd0, odd_par(8'h1C)}, 32'd0);
    check("model_par_F0", {31'd0, odd_par(8'hF0)}, 32'd1);

    // Single good frame.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(40);
    check("1C_code", {24'd0, bus_if.scan_code}, 32'h1C);
    check("1C_valid_count", n_valid - v0, 32'd1);
    check("1C_err_count", n_err - e0, 32'd0);

    // Back-to-back break sequence.
    v0 = n_valid;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(40);
    check("F0_1C_valid_count", n_valid - v0, 32'd2);
    check("F0_1C_code", {24'd0, bus_if.scan_code}, 32'h1C);

    // Bad parity, then bad stop: error only, code held.
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);
    tick(40);
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    tick(40);
    check("badpar_err_count", n_err - e0, 32'd1);
    check("badpar_code", {24'd0, bus_if.scan_code}, 32'h45);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    tick(40);
    check("badstop_err_count", n_err - e0, 32'd2);
    check("bad_valid_count", n_valid - v0, 32'd0);
    check("badstop_code", {24'd0, bus_if.scan_code}, 32'h45);

    // A lone falling edge with data high in idle is ignored.
    v0 = n_valid; e0 = n_err;
    send_bit(1'b1, 1'b0);
    tick(40);
    check("noise_no_strobe", (n_valid - v0) + (n_err - e0), 32'd0);
    check("noise_not_busy", {31'd0, bus_if.busy}, 32'd0);

    // Stalled frame: start plus five data bits, then the clock stays high.
    // frame_err lands after the sync/filter delay (about FILTER_LEN+2
    // cycles) plus TO-1 counted cycles and its register stage.
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.code   = 8'h00;
      exp_q.push_back(e);
    end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    check("stall_busy", {31'd0, bus_if.busy}, 32'd1);
    seen = 1'b0;
    d = 0;
    for (int i = 0; i < TO + 100 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.frame_err) begin
        seen = 1'b1;
        d    = cyc - last_fall_cyc;
      end
    end
    check("timeout_seen", {31'd0, seen}, 32'd1);
    check("timeout_delay_window",
          {31'd0, (d >= TO - 1 + FILTER_LEN) && (d <= TO + FILTER_LEN + 3)}, 32'd1);
    tick(2);
    check("timeout_busy_drop", {31'd0, bus_if.busy}, 32'd0);
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);
    tick(40);
    check("after_timeout_code", {24'd0, bus_if.scan_code}, 32'h45);

    // Short clock glitches inside every bit must not add bits.
    v0 = n_valid;
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    tick(40);
    check("glitch_code", {24'd0, bus_if.scan_code}, 32'h16);
    check("glitch_valid_count", n_valid - v0, 32'd1);

    // Reset in the middle of a frame.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h26 >> i) & 8'h01), 1'b0);
    bus_if.ps2_data = 1'b1;
    rst_n = 1'b0;
    tick(5);
    check("midreset_busy", {31'd0, bus_if.busy}, 32'd0);
    check("midreset_code", {24'd0, bus_if.scan_code}, 32'h00);
    rst_n = 1'b1;
    tick(20);
    v0 = n_valid;
    send_frame(8'h26, 1'b0, 1'b1, 1'b0);
    tick(40);
    check("postreset_code", {24'd0, bus_if.scan_code}, 32'h26);
    check("postreset_valid_count", n_valid - v0, 32'd1);

    // Randomised frames: random codes, speeds, gaps and corruptions.
    for (int n = 0; n < 16; n++) begin
      int kind;
      half = int'($urandom_range(20, 30));
      kind = int'($urandom_range(0, 9));
      send_frame(8'($urandom_range(0, 255)), kind == 0, (kind == 1) ? 1'b0 : 1'b1, 1'b0);
      tick(int'($urandom_range(0, 40)));
    end
    tick(60);
    check("queue_drained", exp_q.size(), 32'd0);
    check("idle_at_end", {31'd0, bus_if.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
